// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: four-channel servo PWM generator.
// Each frame begins by capturing the four joint angles into shadow registers.
// One high pulse per channel follows, with width PULSE_MIN + angle*STEP_CYCLES.
// Because the widths come from the shadow copies, a pulse in flight never changes.
module servo_pwm_gen #(
  parameter int FRAME_CYCLES = 2000000,
  parameter int PULSE_MIN    = 100000,
  parameter int STEP_CYCLES  = 392,
  parameter int CNT_W        = $clog2(FRAME_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] angle_base,
  input  logic [7:0] angle_shoulder,
  input  logic [7:0] angle_elbow,
  input  logic [7:0] angle_gripper,
  output logic [3:0] pwm_out,
  output logic       frame_start,
  output logic       active
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]       pwm_q, pwm_d;
  logic             frame_start_q, frame_start_d;
  logic             active_q, active_d;
  logic [3:0][7:0]  shadow_q, shadow_d;

  logic [3:0][7:0]  angle_in;
  logic [3:0][31:0] width;
  logic [31:0]      cnt_ext;

  // Gather the angle inputs in channel order so they match the pwm_out bit positions.
  always_comb begin
    angle_in[0] = angle_base;
    angle_in[1] = angle_shoulder;
    angle_in[2] = angle_elbow;
    angle_in[3] = angle_gripper;
  end

  // Pulse widths from the shadow angles, computed at 32 bits so the largest value never truncates.
  always_comb begin
    cnt_ext = 32'(frame_cnt_q);
    for (int i = 0; i < 4; i++) begin
      width[i] = 32'(PULSE_MIN) + (32'(shadow_q[i]) * 32'(STEP_CYCLES));
    end
  end

  // Frame sequencing: decide whether a frame starts at the boundary, advance the counter,
  // and end each channel's pulse when the counter reaches that channel's width.
  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    pwm_d         = pwm_q;
    frame_start_d = 1'b0;
    shadow_d      = shadow_q;
    if (frame_cnt_q == '0) begin
      if (enable) begin
        shadow_d      = angle_in;
        pwm_d         = 4'b1111;
        frame_start_d = 1'b1;
        frame_cnt_d   = CNT_W'(1);
        state_d       = RUN;
      end else begin
        state_d = IDLE;
        pwm_d   = 4'b0000;
      end
    end else begin
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
      for (int i = 0; i < 4; i++) begin
        if (cnt_ext == width[i]) begin
          pwm_d[i] = 1'b0;
        end
      end
    end
    active_d = (state_d == RUN);
  end

  // State, counter, shadow and output registers, cleared synchronously by rst_n.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      frame_cnt_q   <= '0;
      pwm_q         <= 4'b0000;
      frame_start_q <= 1'b0;
      active_q      <= 1'b0;
      shadow_q      <= '0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      pwm_q         <= pwm_d;
      frame_start_q <= frame_start_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign frame_start = frame_start_q;
  assign active      = active_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Testbench for servo_pwm_gen with a small frame (1000 cycles).
// A reference frame counter pushes expected widths when a frame is launched.
// A monitor measures each pulse and checks it against the popped expectation.
module tb_servo_pwm_gen;

  localparam int FRAME  = 1000;
  localparam int PMIN   = 100;
  localparam int STEP   = 2;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] angle_base, angle_shoulder, angle_elbow, angle_gripper;
  logic [3:0] pwm_out;
  logic       frame_start;
  logic       active;

  servo_pwm_gen #(
    .FRAME_CYCLES(FRAME),
    .PULSE_MIN(PMIN),
    .STEP_CYCLES(STEP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .angle_base(angle_base),
    .angle_shoulder(angle_shoulder),
    .angle_elbow(angle_elbow),
    .angle_gripper(angle_gripper),
    .pwm_out(pwm_out),
    .frame_start(frame_start),
    .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [3:0][31:0] exp_q[$];

  int m_cnt = 0;
  bit m_run = 1'b0;
  bit m_fs = 1'b0;
  bit started = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] widthOf(input logic [7:0] ang);
    return 32'(PMIN + int'(ang) * STEP);
  endfunction

  // Reference frame counter; pushes expected widths when a frame is launched.
  always @(posedge clk) begin
    started = 1'b1;
    if (!rst_n) begin
      m_cnt = 0;
      m_run = 1'b0;
      m_fs  = 1'b0;
    end else if (m_cnt == 0) begin
      if (enable) begin
        exp_q.push_back({widthOf(angle_gripper), widthOf(angle_elbow),
                         widthOf(angle_shoulder), widthOf(angle_base)});
        m_cnt = 1;
        m_run = 1'b1;
        m_fs  = 1'b1;
      end else begin
        m_run = 1'b0;
        m_fs  = 1'b0;
      end
    end else begin
      m_cnt = (m_cnt == FRAME - 1) ? 0 : m_cnt + 1;
      m_fs  = 1'b0;
    end
  end

  int hi[4];
  int rises[4];
  logic [3:0] prev_pwm = 4'b0;
  bit in_frame = 1'b0;
  bit have_fs = 1'b0;
  int cyc_since_fs = 0;

  task automatic finalizeFrame();
    logic [3:0][31:0] e;
    if (exp_q.size() == 0) begin
      checkOutput("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      for (int ch = 0; ch < 4; ch++) begin
        checkOutput($sformatf("width%0d", ch), 32'(hi[ch]), e[ch]);
        checkOutput($sformatf("rises%0d", ch), 32'(rises[ch]), 32'd1);
      end
    end
  endtask

  // Monitor: per-cycle frame_start/active check, pulse measurement and frame period.
  always @(negedge clk) begin
    if (started) begin
      cyc_since_fs++;
      checkOutput("frame_start", 32'(frame_start), 32'(m_fs));
      checkOutput("active", 32'(active), 32'(m_run));
      if (!rst_n) begin
        in_frame = 1'b0;
        have_fs  = 1'b0;
        exp_q.delete();
      end else begin
        if (in_frame && (frame_start || !active)) begin
          finalizeFrame();
          in_frame = 1'b0;
        end
        if (!active) have_fs = 1'b0;
        if (frame_start) begin
          if (have_fs) checkOutput("period", 32'(cyc_since_fs), 32'(FRAME));
          have_fs = 1'b1;
          cyc_since_fs = 0;
          in_frame = 1'b1;
          prev_pwm = 4'b0;
          for (int ch = 0; ch < 4; ch++) begin
            hi[ch] = 0;
            rises[ch] = 0;
          end
        end
        if (in_frame) begin
          for (int ch = 0; ch < 4; ch++) begin
            if (pwm_out[ch]) begin
              hi[ch]++;
              if (!prev_pwm[ch]) rises[ch]++;
            end
          end
          prev_pwm = pwm_out;
        end else begin
          checkOutput("idle_pwm", 32'(pwm_out), 32'd0);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input logic [7:0] s, input logic [7:0] e, input logic [7:0] g);
    angle_base     = b;
    angle_shoulder = s;
    angle_elbow    = e;
    angle_gripper  = g;
  endtask

  task automatic waitCnt(input int target, input int budget);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (m_cnt != target && n < budget);
    checkOutput("wait_cnt", 32'(m_cnt), 32'(target));
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    applyStimulus(8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pwm", 32'(pwm_out), 32'd0);
    checkOutput("rst_fs", 32'(frame_start), 32'd0);
    checkOutput("rst_active", 32'(active), 32'd0);
    rst_n = 1'b1;

    // Home pose
    applyStimulus(8'd128, 8'd64, 8'd64, 8'd128);
    enable = 1'b1;
    repeat (2 * FRAME) @(posedge clk);
    #1;

    // Extremes
    applyStimulus(8'd0, 8'd255, 8'd0, 8'd255);
    repeat (2 * FRAME) @(posedge clk);
    #1;

    // Mid-frame update of base
    applyStimulus(8'd128, 8'd64, 8'd64, 8'd128);
    waitCnt(FRAME - 1, 1100);
    waitCnt(50, 1100);
    angle_base = 8'd200;
    waitCnt(FRAME - 1, 1100);
    waitCnt(50, 1100);

    // Stop mid-frame
    waitCnt(200, 1100);
    enable = 1'b0;
    waitCnt(FRAME - 1, 1100);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("stop_active", 32'(active), 32'd0);
    for (int i = 0; i < 3; i++) begin
      repeat (100) @(posedge clk);
      #1;
      checkOutput("stop_pwm", 32'(pwm_out), 32'd0);
    end

    // Restart from IDLE
    applyStimulus(8'd10, 8'd20, 8'd30, 8'd40);
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("restart_fs", 32'(frame_start), 32'd1);
    checkOutput("restart_pwm", 32'(pwm_out), 32'hF);
    @(posedge clk);
    #1;

    // Reset mid-pulse
    applyStimulus(8'd10, 8'd20, 8'd30, 8'd200);
    waitCnt(FRAME - 1, 1100);
    waitCnt(300, 1100);
    checkOutput("pre_rst_grip", 32'(pwm_out[3]), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_pwm", 32'(pwm_out), 32'd0);
    checkOutput("midrst_fs", 32'(frame_start), 32'd0);
    checkOutput("midrst_active", 32'(active), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_rst_fs", 32'(frame_start), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back gripper toggling
    for (int f = 0; f < 10; f++) begin
      waitCnt(500, 1100);
      angle_gripper = (f % 2 == 0) ? 8'd50 : 8'd200;
    end
    waitCnt(500, 1100);
    enable = 1'b0;
    waitCnt(FRAME - 1, 1100);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_pwm_gen.md
Name: servo_pwm_gen

Overview:
Four-channel servo PWM generator. It consumes the 8-bit joint angles (base, shoulder, elbow, gripper) produced by the gesture/angle-mapping stage and drives the arm's servo signal pins. Each frame, it latches all four angles into shadow registers, so a pulse in flight is never altered. It then emits one high pulse per channel, with width linear in the latched angle.

Parameters:
FRAME_CYCLES, 2000000, clk cycles per servo frame (20 ms at 100 MHz)
PULSE_MIN, 100000, pulse width in cycles for angle 0 (1 ms)
STEP_CYCLES, 392, added pulse cycles per angle LSB
CNT_W, $clog2(FRAME_CYCLES), frame counter width
Constraints: PULSE_MIN >= 2; PULSE_MIN + 255*STEP_CYCLES < FRAME_CYCLES.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low; clock clk
enable  in  1  run request; sampled only at frame boundaries
angle_base  in  8  base angle, 0..255
angle_shoulder  in  8  shoulder angle
angle_elbow  in  8  elbow angle
angle_gripper  in  8  gripper angle
pwm_out  out  4  servo pulses: [0]=base, [1]=shoulder, [2]=elbow, [3]=gripper
frame_start  out  1  one-cycle pulse, high the cycle after a frame begins
active  out  1  high while a frame is in progress (state RUN)

Behaviour:
- Reset (rst_n low at an edge):
  - frame_cnt=0, state=IDLE.
  - pwm_out=4'b0000, frame_start=0, active=0.
  - Shadow angles = 0.
  - Reset mid-pulse forces pwm_out low on that same edge.
- States:
  - IDLE: frame_cnt held at 0, pwm_out=0.
  - RUN: a frame is in progress.
- Frame boundary, i.e. any edge with frame_cnt==0:
  - If enable=1:
    - Latch all four angle inputs into the shadow registers.
    - Set pwm_out=4'b1111 and frame_start=1.
    - frame_cnt<=1, state<=RUN.
  - If enable=0:
    - state<=IDLE, frame_cnt stays 0, pwm_out stays 0.
- Edge with frame_cnt!=0:
  - frame_cnt<=frame_cnt+1; wraps to 0 when frame_cnt==FRAME_CYCLES-1.
  - frame_start<=0.
- Width per channel:
  - width_i = PULSE_MIN + shadow_i*STEP_CYCLES, computed unsigned and wide enough for the max value (no truncation).
  - pwm_out[i] is cleared at the edge where frame_cnt==width_i.
  - Result: pwm_out[i] is high for exactly width_i cycles, then low until the next frame.
- Frame period is exactly FRAME_CYCLES while enable stays high; consecutive frame_start pulses are FRAME_CYCLES apart.
- Angle inputs changing mid-frame have no effect until the next boundary.
- No glitches: each pwm_out bit has one rising and one falling edge per frame.
- enable deasserted mid-frame:
  - The frame completes with full-width pulses.
  - At the next boundary the block goes IDLE; active drops on that edge.
- enable asserted while IDLE: the frame starts at the next edge, so frame_start is high 1 cycle after enable is sampled.
- active = (state==RUN). Mid-frame it stays 1 regardless of enable.
- All outputs are registered.

Test Plan:
All tests use FRAME_CYCLES=1000, PULSE_MIN=100, STEP_CYCLES=2.
- Home pose: reset, enable=1, angles 128/64/64/128 -> pwm widths 356/228/228/356 cycles; frame_start every 1000 cycles; active=1.
- Extremes: angles 0/255/0/255 -> widths 100/610/100/610; no channel high past cycle 610 of the frame.
- Mid-frame update: base 128->200 at frame_cnt=50 -> current frame base width 356, next frame 500; other channels unchanged.
- Stop: enable=0 at frame_cnt=200 -> current pulses complete at full width; no further frame_start; active=0 after the wrap; pwm_out stays 0.
- Restart and reset:
  - In IDLE, raise enable -> frame_start 1 cycle later, with widths from the inputs at that edge.
  - rst_n low at frame_cnt=300 with pwm_out[3] high -> all outputs 0 on that edge, frame_cnt=0.
- Back-to-back: angle gripper toggling 50/200 every frame for 10 frames -> widths alternate 200/500 exactly, period constant at 1000.
